// File: rtl/queue_ctrl_pkg.sv
// Shared sizing constants for the circular FIFO controller.
package queue_ctrl_pkg;
    localparam int unsigned DW_DEFAULT = 8;
    localparam int unsigned AW_DEFAULT = 4;
    localparam int unsigned DEPTH      = 1 << AW_DEFAULT;
endpackage

// File: rtl/queue_ctrl_ptr_inc.sv
// Wrapping AW-bit pointer register; advances by one when en_i is high.
module ptr_inc #(
    parameter int unsigned AW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en_i,
    output logic [AW-1:0] ptr_o
);
    logic [AW-1:0] ptr_q, ptr_d;

    always_comb begin
        ptr_d = ptr_q;
        if (en_i) ptr_d = ptr_q + AW'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) ptr_q <= '0;
        else     ptr_q <= ptr_d;
    end

    assign ptr_o = ptr_q;
endmodule

// File: rtl/queue_ctrl.sv
// Circular FIFO controller driving an external single-port 16x8 async-read RAM.
module queue_ctrl
    import queue_ctrl_pkg::*;
#(
    parameter int unsigned DW = DW_DEFAULT,
    parameter int unsigned AW = AW_DEFAULT
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          enq,
    input  logic          deq,
    input  logic [DW-1:0] in,
    output logic [DW-1:0] out,
    output logic          full,
    output logic          emp,
    output logic [AW:0]   cnt,
    output logic [AW-1:0] ram_a,
    output logic [DW-1:0] ram_d,
    output logic          ram_we,
    input  logic [DW-1:0] ram_spo
);
    localparam int unsigned Q_DEPTH = 1 << AW;

    logic [AW:0]   cnt_q, cnt_d;
    logic [DW-1:0] out_q, out_d;
    logic [AW-1:0] wp, rp;
    logic          do_enq, do_deq;

    // Flags decode the registered count only, never pointer equality.
    assign full = (cnt_q == (AW+1)'(Q_DEPTH));
    assign emp  = (cnt_q == '0);

    // Single-port RAM: a dequeue wins over a simultaneous enqueue.
    assign do_deq = deq & ~emp & ~rst;
    assign do_enq = enq & ~full & ~do_deq & ~rst;

    assign ram_we = do_enq;
    assign ram_d  = in;
    assign ram_a  = do_enq ? wp : rp;

    ptr_inc #(.AW(AW)) u_wp (.clk(clk), .rst(rst), .en_i(do_enq), .ptr_o(wp));
    ptr_inc #(.AW(AW)) u_rp (.clk(clk), .rst(rst), .en_i(do_deq), .ptr_o(rp));

    always_comb begin
        cnt_d = cnt_q;
        out_d = out_q;
        if (do_enq) cnt_d = cnt_q + (AW+1)'(1);
        if (do_deq) begin
            cnt_d = cnt_q - (AW+1)'(1);
            out_d = ram_spo;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
            out_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            out_q <= out_d;
        end
    end

    assign cnt = cnt_q;
    assign out = out_q;
endmodule

// File: tb/tb_queue_ctrl.sv
// Randomised and directed bench for queue_ctrl against a queue-based FIFO model.
module tb_queue_ctrl;
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       enq = 1'b0;
    logic       deq = 1'b0;
    logic [7:0] in  = 8'h00;
    logic [7:0] out, ram_d, ram_spo;
    logic       full, emp, ram_we;
    logic [4:0] cnt;
    logic [3:0] ram_a;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    queue_ctrl dut (
        .clk(clk), .rst(rst), .enq(enq), .deq(deq), .in(in), .out(out),
        .full(full), .emp(emp), .cnt(cnt), .ram_a(ram_a), .ram_d(ram_d),
        .ram_we(ram_we), .ram_spo(ram_spo)
    );

    // External RAM stand-in: synchronous write, asynchronous read.
    logic [7:0] mem [16];
    always @(posedge clk) if (ram_we) mem[ram_a] <= ram_d;
    assign ram_spo = mem[ram_a];

    // Behavioural model: a plain queue plus running enqueue/dequeue totals.
    byte unsigned q[$];
    int           wr_n, rd_n;
    logic [7:0]   out_m;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            q.delete();
            wr_n  = 0;
            rd_n  = 0;
            out_m = 8'h00;
        end else begin
            if (deq && q.size() > 0) begin
                out_m = q.pop_front();
                rd_n++;
            end else if (enq && q.size() < 16) begin
                q.push_back(in);
                wr_n++;
            end
        end
    end

    always @(negedge clk) begin
        bit m_enq, m_deq;
        if (rst) begin
            check("rst_cnt", 32'(cnt), 0);
            check("rst_emp", 32'(emp), 1);
            check("rst_full", 32'(full), 0);
            check("rst_out", 32'(out), 0);
            check("rst_we", 32'(ram_we), 0);
        end else begin
            m_deq = deq && q.size() > 0;
            m_enq = enq && q.size() < 16 && !m_deq;
            check("cnt", 32'(cnt), 32'(q.size()));
            check("full", 32'(full), 32'(q.size() == 16));
            check("emp", 32'(emp), 32'(q.size() == 0));
            check("out", 32'(out), 32'(out_m));
            check("ram_we", 32'(ram_we), 32'(m_enq));
            check("ram_a", 32'(ram_a), m_enq ? 32'(wr_n % 16) : 32'(rd_n % 16));
            check("ram_d", 32'(ram_d), 32'(in));
        end
    end

    task automatic cyc(input bit e, input bit d, input logic [7:0] v);
        enq = e; deq = d; in = v;
        @(posedge clk); #1;
        enq = 1'b0; deq = 1'b0;
    endtask

    task automatic enq_chk(input logic [7:0] v, input int exp_a, input bit exp_we);
        enq = 1'b1; deq = 1'b0; in = v;
        @(negedge clk);
        check("enq_we", 32'(ram_we), 32'(exp_we));
        if (exp_we) check("enq_addr", 32'(ram_a), 32'(exp_a));
        @(posedge clk); #1;
        enq = 1'b0;
    endtask

    task automatic deq_chk(input logic [7:0] exp_v);
        cyc(1'b0, 1'b1, 8'h00);
        check("deq_out", 32'(out), 32'(exp_v));
    endtask

    task automatic do_reset();
        @(negedge clk); #2;
        rst = 1'b1;
        #1;
        check("async_cnt", 32'(cnt), 0);
        check("async_emp", 32'(emp), 1);
        @(posedge clk); #2;
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    initial begin
        #2 rst = 1'b1;
        #10 rst = 1'b0;
        @(posedge clk); #1;
        repeat (3) @(posedge clk);
        #1;
        check("idle_emp", 32'(emp), 1);
        check("idle_cnt", 32'(cnt), 0);
        check("idle_out", 32'(out), 0);
        check("idle_a", 32'(ram_a), 0);

        // Three in, three out.
        enq_chk(8'h11, 0, 1);
        enq_chk(8'h22, 1, 1);
        enq_chk(8'h33, 2, 1);
        check("cnt3", 32'(cnt), 3);
        deq_chk(8'h11);
        deq_chk(8'h22);
        deq_chk(8'h33);
        check("emp3", 32'(emp), 1);

        // Fill to 16, overflow attempt, drain.
        for (int i = 0; i < 16; i++) enq_chk(8'(i + 1), (3 + i) % 16, 1);
        check("full16", 32'(full), 1);
        check("cnt16", 32'(cnt), 16);
        enq_chk(8'hFF, 0, 0);
        check("cnt_ovf", 32'(cnt), 16);
        for (int i = 0; i < 16; i++) deq_chk(8'(i + 1));
        check("drain_emp", 32'(emp), 1);
        deq_chk(8'h10);

        // Pointer wrap from a fresh reset.
        do_reset();
        for (int i = 0; i < 10; i++) cyc(1'b1, 1'b0, 8'(i));
        for (int i = 0; i < 10; i++) cyc(1'b0, 1'b1, 8'h00);
        for (int i = 0; i < 10; i++) enq_chk(8'hA0 + 8'(i), (10 + i) % 16, 1);
        for (int i = 0; i < 10; i++) deq_chk(8'hA0 + 8'(i));

        // Simultaneous enq/deq: non-empty then empty.
        cyc(1'b1, 1'b0, 8'h07);
        cyc(1'b1, 1'b1, 8'h55);
        check("sim_out", 32'(out), 8'h07);
        check("sim_cnt0", 32'(cnt), 0);
        cyc(1'b1, 1'b1, 8'h66);
        check("sim_cnt1", 32'(cnt), 1);
        check("sim_head", 32'(ram_spo), 8'h66);
        deq_chk(8'h66);

        // Twenty enq/deq pairs must leave the count intact.
        for (int i = 0; i < 20; i++) begin
            cyc(1'b1, 1'b0, 8'(i * 3));
            cyc(1'b0, 1'b1, 8'h00);
        end
        check("pairs_cnt", 32'(cnt), 0);
        check("pairs_out", 32'(out), 32'(8'(19 * 3)));

        // Async reset with five entries held, then an ignored deq.
        for (int i = 0; i < 5; i++) cyc(1'b1, 1'b0, 8'hC0 + 8'(i));
        check("five_cnt", 32'(cnt), 5);
        do_reset();
        deq_chk(8'h00);

        // Random traffic: fill-biased, drain-biased, then balanced.
        for (int p = 0; p < 3; p++) begin
            for (int i = 0; i < 200; i++) begin
                int pe, pd;
                pe = (p == 0) ? 80 : (p == 1) ? 20 : 50;
                pd = 100 - pe;
                cyc($urandom_range(0, 99) < pe, $urandom_range(0, 99) < pd, 8'($urandom));
            end
        end

        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/queue_ctrl.md
Name: queue_ctrl

Overview:
- Circular FIFO controller placed directly upstream of the 16x8 distributed RAM (DRAM: a[3:0], d[7:0], we, clk, async-read spo[7:0]).
- Accepts enqueue/dequeue requests from the button/debounce front end.
- Generates the RAM's address, write data and write enable, and captures spo into a registered output.
- Tracks head/tail pointers and count, and flags full/empty for the display logic.

Parameters:
- DW, 8, data width; matches the RAM d/spo width.
- AW, 4, RAM address width; queue depth is 2**AW = 16.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  reset, asynchronous, active-high; clears all state.
- enq  input  1  enqueue request, one-cycle pulse, already synchronised and debounced upstream.
- deq  input  1  dequeue request, one-cycle pulse, already synchronised and debounced upstream.
- in  input  DW  data to enqueue; sampled in the cycle enq is accepted.
- out  output  DW  last dequeued value (registered).
- full  output  1  high when count == 16.
- emp  output  1  high when count == 0.
- cnt  output  AW+1  current occupancy, 0..16.
- ram_a  output  AW  RAM address; drives DRAM a.
- ram_d  output  DW  RAM write data; drives DRAM d.
- ram_we  output  1  RAM write enable; drives DRAM we.
- ram_spo  input  DW  RAM async read data; from DRAM spo.

Behaviour:
- Reset (async, rst=1):
  - wp=0, rp=0, cnt=0, out=0.
  - full=0, emp=1.
  - ram_we=0 combinationally while in reset.
- Accept rules, evaluated combinationally each cycle:
  - do_enq = enq & ~full & ~(deq & ~emp).
  - do_deq = deq & ~emp.
- Simultaneous enq and deq:
  - Non-empty: the dequeue is served and the enqueue is dropped (not buffered). The RAM is single-port, so only one address is valid per cycle.
  - Empty: the enqueue is served and the dequeue is ignored.
- RAM drive, combinational:
  - ram_we = do_enq; ram_d = in.
  - ram_a = wp when do_enq, otherwise rp. The idle address is rp, so ram_spo always shows the head entry.
- On a clock edge with do_enq:
  - The RAM writes in at address wp (write happens inside the RAM).
  - wp <= wp+1 (AW-bit wrap, 15 -> 0); cnt <= cnt+1.
- On a clock edge with do_deq:
  - out <= ram_spo, the entry at rp.
  - rp <= rp+1 (wrap 15 -> 0); cnt <= cnt-1.
- Latency: out updates on the edge that accepts deq and is visible the cycle after the deq pulse. Enqueued data is readable at the head one cycle after acceptance.
- Flags:
  - full = (cnt == 16); emp = (cnt == 0).
  - Derived from cnt, which is registered, so both flags are glitch-free.
  - Pointer equality alone is never used for full/empty.
- Boundaries:
  - enq while full: ignored. No write, no pointer or count change, ram_we stays 0.
  - deq while empty: ignored. out holds its value.
  - Wrap-around: wp and rp wrap independently. A sequence of 20 enq/deq pairs must not corrupt cnt.
- Reset mid-operation: any cycle with rst=1 returns to the reset state immediately. RAM contents are not cleared; they become don't-care because cnt=0.
- No internal state machine beyond the pointers and count. Do not add an extra registered stage in front of the RAM; it would break the single-cycle write.

Decomposition:
- Shared package: DW and AW defaults, and DEPTH = 1 << AW.
- Sub-module: ptr_inc, a wrapping AW-bit pointer register with en, clk and rst. Instantiate it twice, for wp and rp.
- The RAM itself stays outside this block. The top level wires ram_* to DRAM.

Test Plan:
- Reset, then idle 3 cycles -> emp=1, full=0, cnt=0, out=0x00, ram_we=0, ram_a=0.
- Enqueue 0x11, 0x22, 0x33 on consecutive cycles -> ram_we pulses with ram_a = 0, 1, 2; cnt=3. Then three deq pulses -> out = 0x11, 0x22, 0x33 in order; emp=1.
- Enqueue 16 values 0x01..0x10 -> full=1, cnt=16. A 17th enq of 0xFF -> ram_we=0 and cnt stays 16. Dequeueing all 16 -> out ends at 0x10 and 0xFF is never seen.
- Pointer wrap: 10 enq plus 10 deq, then enqueue 0xA0..0xA9 -> writes go to addresses 10..15 then 0..3. Dequeues return 0xA0..0xA9 in order.
- Simultaneous enq=1 (in=0x55) and deq=1 with queue holding [0x07] -> out=0x07, cnt=0, and 0x55 is not stored. Then simultaneous enq (0x66) and deq on the empty queue -> cnt=1, and the head reads 0x66.
- Assert rst asynchronously mid-sequence (queue holds 5 entries) -> cnt=0 and emp=1 without waiting for a clock edge. A following deq is ignored and out=0x00.
